uart_word_loader: RTL and testbench

UART_WORD_LOADER -- requirements
Module: uart_word_loader

---
 rtl/uart_word_loader_pkg.sv | 24 ++
 rtl/uart_word_loader_if.sv | 24 ++
 rtl/uart_word_loader_baud_rate_gen.sv | 30 +++
 rtl/uart_word_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_word_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_loader_pkg.sv
// Shared definitions for the UART word loader: receiver state encoding,
// oversampling constants and the halt word that ends a load.
package uart_word_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int          OVERSAMPLE = 16;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam logic [3:0]  TICK_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  TICK_LAST  = 4'(OVERSAMPLE - 1);

    // Clocks per oversample tick; never below one so the divider stays legal.
    function automatic int baud_div(input int clk_freq, input int baud);
        int div_v;
        div_v = clk_freq / (baud * OVERSAMPLE);
        return (div_v < 1) ? 1 : div_v;
    endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// Serial input, load control and loader outputs bundled for the word loader.
interface uart_word_loader_if #(
    parameter int ADDR_W = 8
);
    logic              RX_INPUT;
    logic              load_en;
    logic              o_byte_valid;
    logic [7:0]        o_byte;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_frame_err;
    logic              o_done;

    modport slave (
        input  RX_INPUT, load_en,
        output o_byte_valid, o_byte, o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_done
    );

    modport master (
        output RX_INPUT, load_en,
        input  o_byte_valid, o_byte, o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_done
    );
endinterface

// File: rtl/uart_word_loader_baud_rate_gen.sv
// Free-running divider producing a one-cycle pulse at 16x the serial bit rate.
module baud_rate_gen
    import uart_word_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);
    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Count 0..DIV-1 and pulse the tick on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            baud_tick <= 1'b0;
        end else if (cnt_r == CNT_W'(DIV - 1)) begin
            cnt_r     <= '0;
            baud_tick <= 1'b1;
        end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
            baud_tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_word_loader.sv
// 8N1 UART receiver that packs received bytes big-endian into 32-bit words
// and writes them to sequential instruction-memory addresses.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int ADDR_W     = 8,
    parameter int WORD_COUNT = 256
) (
    input  logic CLK100MHZ,
    input  logic SWITCH_RESET,
    uart_word_loader_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    logic              baud_tick_s;
    logic [1:0]        sync_r;
    logic              rx_s;
    rx_state_t         state_r, state_s;
    logic [3:0]        tick_cnt_r, tick_cnt_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic [7:0]        shift_r, shift_s;
    logic              byte_ok_s, frame_bad_s;
    logic [7:0]        byte_r;
    logic              byte_valid_r, frame_err_r;
    logic [31:0]       word_r, wr_data_r;
    logic [1:0]        idx_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              wr_en_r, done_r;

    baud_rate_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (
        .clk       (CLK100MHZ),
        .rst       (SWITCH_RESET),
        .baud_tick (baud_tick_s)
    );

    assign rx_s = sync_r[1];

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) sync_r <= 2'b11;
        else              sync_r <= {sync_r[0], bus.RX_INPUT};
    end

    // Receiver state and counters.
    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            state_r    <= RX_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
        end
    end

    // Receiver next-state: confirm start at mid-bit, then sample every 16 ticks.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        byte_ok_s   = 1'b0;
        frame_bad_s = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_s    = RX_START;
                    tick_cnt_s = 4'd0;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_tick_s && (tick_cnt_r == TICK_MID)) begin
                    tick_cnt_s = 4'd0;
                    bit_cnt_s  = 3'd0;
                    state_s    = rx_s ? RX_IDLE : RX_DATA;
                end else if (baud_tick_s) begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            RX_DATA: begin
                if (baud_tick_s && (tick_cnt_r == TICK_LAST)) begin
                    tick_cnt_s = 4'd0;
                    shift_s    = {rx_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_s = 3'd0;
                        state_s   = RX_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else if (baud_tick_s) begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            RX_STOP: begin
                if (baud_tick_s && (tick_cnt_r == TICK_LAST)) begin
                    tick_cnt_s = 4'd0;
                    state_s    = RX_IDLE;
                    if (rx_s) byte_ok_s   = 1'b1;
                    else      frame_bad_s = 1'b1;
                end else if (baud_tick_s) begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                state_s    = RX_IDLE;
                tick_cnt_s = 4'd0;
                bit_cnt_s  = 3'd0;
            end
        endcase
    end

    // Byte outputs: valid pulses the cycle after a good stop bit; frame error is sticky.
    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= byte_ok_s;
            if (byte_ok_s)   byte_r      <= shift_r;
            if (frame_bad_s) frame_err_r <= 1'b1;
        end
    end

    // Word assembler; the address only advances after the strobe and never wraps.
    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            word_r    <= 32'h0000_0000;
            wr_data_r <= 32'h0000_0000;
            idx_r     <= 2'd0;
            wr_addr_r <= '0;
            wr_en_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            if (wr_en_r) begin
                if ((wr_data_r == HALT_WORD) || (wr_addr_r == LAST_ADDR)) done_r <= 1'b1;
                if (wr_addr_r != LAST_ADDR) wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end
            if (!bus.load_en) begin
                idx_r <= 2'd0;
            end else if (byte_valid_r && !done_r) begin
                word_r <= {word_r[23:0], byte_r};
                idx_r  <= idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    wr_data_r <= {word_r[23:0], byte_r};
                    wr_en_r   <= 1'b1;
                end
            end
        end
    end

    assign bus.o_byte_valid = byte_valid_r;
    assign bus.o_byte       = byte_r;
    assign bus.o_wr_en      = wr_en_r;
    assign bus.o_wr_addr    = wr_addr_r;
    assign bus.o_wr_data    = wr_data_r;
    assign bus.o_frame_err  = frame_err_r;
    assign bus.o_done       = done_r;
endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized bench for uart_word_loader against a byte/word-level reference model.
module tb_uart_word_loader;
    import uart_word_loader_pkg::*;

    localparam int CLK_FREQ   = 4_800_000;
    localparam int BAUD       = 100_000;
    localparam int ADDR_W     = 8;
    localparam int WORD_COUNT = 4;
    localparam int DIV        = CLK_FREQ / (BAUD * 16);
    localparam int BIT        = DIV * 16;
    localparam int BAD_STOP   = BIT / 2 + 2 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_word_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_word_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W), .WORD_COUNT(WORD_COUNT)
    ) dut (
        .CLK100MHZ    (clk),
        .SWITCH_RESET (rst),
        .bus          (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  got_bytes[$], exp_bytes[$];
    logic [40:0] got_wr[$], exp_wr[$];   // {strobe followed a byte pulse, addr, data}

    int          m_idx, m_addr;
    logic [31:0] m_word;
    bit          m_done, m_ferr;

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (bus.o_byte_valid === 1'b1) got_bytes.push_back(bus.o_byte);
        if (bus.o_wr_en === 1'b1) got_wr.push_back({prev_valid, bus.o_wr_addr, bus.o_wr_data});
        prev_valid = bus.o_byte_valid;
    end

    function automatic void model_reset();
        m_idx = 0; m_addr = 0; m_word = 32'h0; m_done = 1'b0; m_ferr = 1'b0;
        exp_bytes.delete(); exp_wr.delete(); got_bytes.delete(); got_wr.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        if (bus.load_en && !m_done) begin
            m_word = {m_word[23:0], b};
            m_idx  = m_idx + 1;
            if (m_idx == 4) begin
                m_idx = 0;
                exp_wr.push_back({1'b1, 8'(m_addr), m_word});
                if (m_word == 32'hFFFF_FFFF || m_addr == WORD_COUNT - 1) m_done = 1'b1;
                if (m_addr != WORD_COUNT - 1) m_addr = m_addr + 1;
            end
        end
    endfunction

    task automatic set_load(input logic v);
        @(negedge clk);
        bus.load_en = v;
        if (!v) m_idx = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good, input int idle_bits);
        @(negedge clk);
        bus.RX_INPUT = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX_INPUT = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (good) begin
            bus.RX_INPUT = 1'b1;
            repeat (BIT) @(negedge clk);
            model_byte(b);
        end else begin
            bus.RX_INPUT = 1'b0;
            repeat (BAD_STOP) @(negedge clk);
            m_ferr = 1'b1;
        end
        bus.RX_INPUT = 1'b1;
        repeat (idle_bits * BIT) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.RX_INPUT = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.RX_INPUT = 1'b1; bus.load_en = 1'b0; rst = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.o_byte !== 8'h00 || bus.o_byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_byte: got byte=%h valid=%b, want 00/0", bus.o_byte, bus.o_byte_valid);
        end
        vectors++;
        if (bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== 8'h00 || bus.o_wr_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wr: got en=%b addr=%h data=%h, want 0/00/00000000",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
        end
        vectors++;
        if (bus.o_frame_err !== 1'b0 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got ferr=%b done=%b, want 0/0", bus.o_frame_err, bus.o_done);
        end
        rst = 1'b0;
        model_reset();
        repeat (2 * BIT) @(negedge clk);
        vectors++;
        if (got_bytes.size() != 0) begin
            miscompares++;
            $display("FAIL reset_idle: got %0d bytes after release, want 0", got_bytes.size());
        end
    endtask

    task automatic test_byte_no_load();
        set_load(1'b0);
        send_frame(8'h55, 1'b1, 2);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1);
        vectors++;
        if (got_bytes.size() != exp_bytes.size()) begin
            miscompares++;
            $display("FAIL noload_count: got %0d bytes, want %0d", got_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                vectors++;
                if (got_bytes[i] !== exp_bytes[i]) begin
                    miscompares++;
                    $display("FAIL noload_byte%0d: got %h, want %h", i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
        vectors++;
        if (got_wr.size() != 0) begin
            miscompares++;
            $display("FAIL noload_wr: got %0d writes, want 0", got_wr.size());
        end
        vectors++;
        if (bus.o_byte !== exp_bytes[exp_bytes.size()-1]) begin
            miscompares++;
            $display("FAIL noload_hold: got %h, want %h", bus.o_byte, exp_bytes[exp_bytes.size()-1]);
        end
        got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_word_load();
        logic [31:0] w;
        set_load(1'b1);
        send_frame(8'h20, 1'b1, 1); send_frame(8'h08, 1'b1, 1);
        send_frame(8'h00, 1'b1, 1); send_frame(8'h05, 1'b1, 2);
        vectors++;
        if (got_wr.size() != 1 || got_wr[0] !== {1'b1, 8'h00, 32'h2008_0005}) begin
            miscompares++;
            $display("FAIL word_first: got %0d writes first=%h, want 1 of %h",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 41'h0, {1'b1, 8'h00, 32'h2008_0005});
        end
        vectors++;
        if (bus.o_wr_addr !== 8'(m_addr) || m_addr != 1) begin
            miscompares++;
            $display("FAIL word_addr1: got %0d, want 1", bus.o_wr_addr);
        end
        got_wr.delete(); exp_wr.delete();
        w = $urandom & 32'h7FFF_FFFF;
        for (int i = 3; i >= 0; i--) send_frame(w[i*8 +: 8], 1'b1, 1);
        repeat (BIT) @(negedge clk);
        vectors++;
        if (got_wr.size() != 1 || got_wr[0] !== exp_wr[0]) begin
            miscompares++;
            $display("FAIL word_rand: got %0d writes first=%h, want %h",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 41'h0, exp_wr[0]);
        end
        vectors++;
        if (bus.o_wr_addr !== 8'(m_addr) || bus.o_done !== m_done) begin
            miscompares++;
            $display("FAIL word_state: got addr=%0d done=%b, want %0d/%b", bus.o_wr_addr, bus.o_done, m_addr, m_done);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_frame_error();
        logic [31:0] w;
        w = $urandom & 32'h7FFF_FFFF;
        send_frame(w[31:24], 1'b1, 1); send_frame(w[23:16], 1'b1, 1);
        send_frame(8'hA3, 1'b0, 2);
        vectors++;
        if (bus.o_frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ferr_set: got %b, want 1", bus.o_frame_err);
        end
        vectors++;
        if (got_bytes.size() != 2) begin
            miscompares++;
            $display("FAIL ferr_nobyte: got %0d bytes, want 2", got_bytes.size());
        end
        send_frame(w[15:8], 1'b1, 1); send_frame(w[7:0], 1'b1, 2);
        vectors++;
        if (got_wr.size() != 1 || got_wr[0] !== exp_wr[0]) begin
            miscompares++;
            $display("FAIL ferr_word: got %0d writes first=%h, want %h",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 41'h0, exp_wr[0]);
        end
        vectors++;
        if (bus.o_frame_err !== m_ferr) begin
            miscompares++;
            $display("FAIL ferr_sticky: got %b, want %b", bus.o_frame_err, m_ferr);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_addr_limit();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 254)), 1'b1, 1);
        repeat (BIT) @(negedge clk);
        vectors++;
        if (got_wr.size() != exp_wr.size() || (exp_wr.size() > 0 && got_wr[0] !== exp_wr[0])) begin
            miscompares++;
            $display("FAIL limit_writes: got %0d writes, want %0d", got_wr.size(), exp_wr.size());
        end
        vectors++;
        if (bus.o_done !== m_done || bus.o_wr_addr !== 8'(m_addr)) begin
            miscompares++;
            $display("FAIL limit_state: got done=%b addr=%0d, want %b/%0d", bus.o_done, bus.o_wr_addr, m_done, m_addr);
        end
        vectors++;
        if (got_bytes.size() != 8) begin
            miscompares++;
            $display("FAIL limit_bytes: got %0d bytes, want 8", got_bytes.size());
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_halt();
        pulse_reset();
        set_load(1'b1);
        for (int i = 0; i < 4; i++) send_frame(8'h00, 1'b1, 1);
        for (int i = 0; i < 4; i++) send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h12, 1'b1, 1); send_frame(8'h34, 1'b1, 1);
        send_frame(8'h56, 1'b1, 1); send_frame(8'h78, 1'b1, 2);
        vectors++;
        if (got_wr.size() != 2) begin
            miscompares++;
            $display("FAIL halt_count: got %0d writes, want 2", got_wr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (got_wr[i] !== exp_wr[i]) begin
                    miscompares++;
                    $display("FAIL halt_wr%0d: got %h, want %h", i, got_wr[i], exp_wr[i]);
                end
            end
        end
        vectors++;
        if (bus.o_done !== 1'b1 || got_bytes.size() != 12) begin
            miscompares++;
            $display("FAIL halt_done: got done=%b bytes=%0d, want 1/12", bus.o_done, got_bytes.size());
        end
        vectors++;
        if (bus.o_byte !== 8'h78) begin
            miscompares++;
            $display("FAIL halt_lastbyte: got %h, want 78", bus.o_byte);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_load_drop();
        pulse_reset();
        set_load(1'b1);
        send_frame(8'($urandom), 1'b1, 1); send_frame(8'($urandom), 1'b1, 1);
        set_load(1'b0);
        send_frame(8'($urandom), 1'b1, 1);
        set_load(1'b1);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 254)), 1'b1, 1);
        repeat (BIT) @(negedge clk);
        vectors++;
        if (got_wr.size() != 1 || got_wr[0] !== exp_wr[0]) begin
            miscompares++;
            $display("FAIL drop_word: got %0d writes first=%h, want %h",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 41'h0, exp_wr[0]);
        end
        vectors++;
        if (bus.o_wr_addr !== 8'(m_addr)) begin
            miscompares++;
            $display("FAIL drop_addr: got %0d, want %0d", bus.o_wr_addr, m_addr);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        @(negedge clk);
        bus.RX_INPUT = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        bus.RX_INPUT = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        vectors++;
        if (got_bytes.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_nobyte: got %0d bytes, want 0", got_bytes.size());
        end
        b = 8'($urandom);
        send_frame(b, 1'b1, 2);
        vectors++;
        if (got_bytes.size() != 1 || got_bytes[0] !== b) begin
            miscompares++;
            $display("FAIL glitch_recover: got %0d bytes first=%h, want 1 of %h",
                     got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'h00, b);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        bus.RX_INPUT = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.RX_INPUT = b[i];
            repeat (BIT) @(negedge clk);
        end
        bus.RX_INPUT = b[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        bus.RX_INPUT = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.o_byte_valid, bus.o_byte, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_frame_err, bus.o_done} !== 52'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got byte=%h addr=%h data=%h ferr=%b done=%b, want all zero",
                     bus.o_byte, bus.o_wr_addr, bus.o_wr_data, bus.o_frame_err, bus.o_done);
        end
        rst = 1'b0;
        model_reset();
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h3C, 1'b1, 2);
        vectors++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 8'h3C || bus.o_frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_resume: got %0d bytes first=%h ferr=%b, want 1 of 3c ferr 0",
                     got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'h00, bus.o_frame_err);
        end
        got_wr.delete(); exp_wr.delete(); got_bytes.delete(); exp_bytes.delete();
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        set_load(1'b1);
        for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1, 0);
        repeat (2 * BIT) @(negedge clk);
        vectors++;
        if (got_bytes.size() != exp_bytes.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d bytes, want %0d", got_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                vectors++;
                if (got_bytes[i] !== exp_bytes[i]) begin
                    miscompares++;
                    $display("FAIL b2b_byte%0d: got %h, want %h", i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
        vectors++;
        if (got_wr.size() != exp_wr.size()) begin
            miscompares++;
            $display("FAIL b2b_wrcount: got %0d writes, want %0d", got_wr.size(), exp_wr.size());
        end else begin
            for (int i = 0; i < exp_wr.size(); i++) begin
                vectors++;
                if (got_wr[i] !== exp_wr[i]) begin
                    miscompares++;
                    $display("FAIL b2b_wr%0d: got %h, want %h", i, got_wr[i], exp_wr[i]);
                end
            end
        end
        vectors++;
        if (bus.o_wr_addr !== 8'(m_addr) || bus.o_done !== m_done) begin
            miscompares++;
            $display("FAIL b2b_state: got addr=%0d done=%b, want %0d/%b", bus.o_wr_addr, bus.o_done, m_addr, m_done);
        end
    endtask

    initial begin
        test_reset();
        test_byte_no_load();
        test_word_load();
        test_frame_error();
        test_addr_limit();
        test_halt();
        test_load_drop();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
